comar_nor_sched: RTL and testbench
==================================

COMAR_NOR_SCHED -- requirements
Module: comar_nor_sched

Interface
REQ-001 Parameter SEED, default 31'h0000_0001; reset value of the mask LFSR.
REQ-002 Parameter CNT_W, default 16; width of the issued-operation counter.
REQ-003 Port clk, input, 1; sole clock, rising edge.
REQ-004 Port rst, input, 1; reset, synchronous and active-high.
REQ-005 Port seed_valid, input, 1; load seed into the LFSR this cycle.
REQ-006 Port seed, input, 31; LFSR seed value.
REQ-007 Ports req0_valid, req1_valid, input, 1 each; requester has an operand pair.
REQ-008 Ports req0_a, req0_b, req1_a, req1_b, input, 2 each; Boolean-masked operand shares.
REQ-009 Ports req0_ready, req1_ready, output, 1 each; grant, the operand pair is accepted this cycle.
REQ-010 Ports g_a, g_b, output, 2 each; operand shares driven to the 2-cycle masked NOR gadget.
REQ-011 Port g_r, output, 6; fresh randomness to the gadget.
REQ-012 Port g_c, input, 2; gadget result shares.
REQ-013 Ports rsp0_valid, rsp1_valid, output, 1 each; result for that requester is valid.
REQ-014 Ports rsp0_c, rsp1_c, output, 2 each; result shares, equal to g_c.
REQ-015 Port busy, output, 1; any operation is in flight.
REQ-016 Port op_count, output, CNT_W; number of accepted operations.

Function
REQ-017 Arbitration: round-robin between the two requesters; only one grant per cycle; readyX is combinational and has no dependency on reqX_a or reqX_b.
REQ-018 With a single valid requester, that requester is granted; with both valid, the requester not granted most recently is granted; the pointer updates only on a grant.
REQ-019 While seed_valid=1, both readys are 0.
REQ-020 On an accepted pair in cycle n, g_a and g_b carry its shares in cycle n; in other cycles g_a=g_b=2'b00.
REQ-021 Latency: an operation accepted in cycle n produces rspX_valid=1 in cycle n+2 for the same requester only; throughput is one operation per cycle; no backpressure on responses.
REQ-022 A 2-deep valid/tag shift pipeline tracks in-flight operations; the tag is the requester id.
REQ-023 rsp0_c=rsp1_c=g_c unconditionally; consumers qualify with rspX_valid.
REQ-024 The LFSR is 31-bit Fibonacci, polynomial x^31+x^28+1, and advances exactly 6 steps every cycle, including idle cycles; g_r=lfsr[5:0] (registered state).
REQ-025 Consequence of REQ-024: g_r[1:0] in cycle n and g_r[5:2] in cycle n+1 are fresh for the operation issued in cycle n, with no bit reused across cycles.
REQ-026 seed_valid=1 loads seed in place of the advance; a seed of zero loads SEED instead, so the LFSR never reaches the all-zero lock state.
REQ-027 op_count increments by 1 per grant and wraps modulo 2^CNT_W.
REQ-028 busy = OR of both pipeline valid bits.

Reset
REQ-029 When rst=1 at a rising edge, it clears both pipeline valids and sets op_count=0, the RR pointer to favour req0, and the LFSR to SEED.
REQ-030 Reset has priority over seed_valid and over grants.
REQ-031 Any in-flight operation is discarded by reset: rsp valids are 0 from the first cycle after reset.
REQ-032 During a cycle with rst=1, readys are 0.

Structure
REQ-033 Shared package comar_pkg holds the LFSR width (31), the tap positions, the gadget latency (2) and the randomness width (6).
REQ-034 One sub-module, comar_lfsr6: parameterised seed, 6-step unrolled update, seed-load port.
REQ-035 The gadget is instantiated outside this block; no gadget logic lives here.

Verification
REQ-036 Reset, then req0 a=2'b01, b=2'b00 in cycle 0 -> rsp0_valid in cycle 2, rsp0_c[0]^rsp0_c[1]=0; rsp1_valid stays 0.
REQ-037 Both valid continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; op_count=6; responses alternate in cycles 2-7.
REQ-038 seed_valid=1 with seed=0 -> LFSR=31'h1 next cycle; readys are 0 during the load cycle.
REQ-039 rst asserted in cycle 1 after acceptance in cycle 0 -> no rsp_valid in cycles 2-3; busy=0 after reset.
REQ-040 1000 cycles of random traffic -> each rspX value matches NOR of the unmasked operands; g_r is never stuck; op_count equals the number of grants mod 2^16.
REQ-041 op_count preset by 65535 grants, then one more grant -> op_count=0.

Source files
------------

// File: rtl/comar_pkg.sv
// Shared constants and types for the masked-NOR operation scheduler.
package comar_pkg;

  localparam int unsigned LFSR_W     = 31;
  localparam int unsigned TAP_HI     = 30;
  localparam int unsigned TAP_LO     = 27;
  localparam int unsigned GADGET_LAT = 2;
  localparam int unsigned RAND_W     = 6;
  localparam int unsigned SHARE_W    = 2;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e tag;
  } pipe_stage_t;

  // One Fibonacci step of x^31 + x^28 + 1; feedback enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/comar_lfsr6.sv
// Mask LFSR advancing RAND_W steps per cycle, with a seed-load port.
module comar_lfsr6
  import comar_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 31'h0000_0001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [LFSR_W-1:0]   seed,
  output logic [RAND_W-1:0]   rnd
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] adv_c;

  // Unrolled multi-step advance so no random bit is ever handed out twice.
  always_comb begin
    adv_c = state_q;
    for (int unsigned i = 0; i < RAND_W; i++) begin
      adv_c = lfsr_step(adv_c);
    end
  end

  // A zero seed would lock the register, so it falls back to SEED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= (seed == '0) ? SEED : seed;
    end else begin
      state_q <= adv_c;
    end
  end

  assign rnd = state_q[RAND_W-1:0];

endmodule

// File: rtl/comar_nor_sched.sv
// Two-requester round-robin scheduler feeding an external 2-cycle masked NOR gadget.
module comar_nor_sched
  import comar_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 31'h0000_0001,
  parameter int unsigned       CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                seed_valid,
  input  logic [LFSR_W-1:0]   seed,
  input  logic                req0_valid,
  input  logic [SHARE_W-1:0]  req0_a,
  input  logic [SHARE_W-1:0]  req0_b,
  input  logic                req1_valid,
  input  logic [SHARE_W-1:0]  req1_a,
  input  logic [SHARE_W-1:0]  req1_b,
  output logic                req0_ready,
  output logic                req1_ready,
  output logic [SHARE_W-1:0]  g_a,
  output logic [SHARE_W-1:0]  g_b,
  output logic [RAND_W-1:0]   g_r,
  input  logic [SHARE_W-1:0]  g_c,
  output logic                rsp0_valid,
  output logic                rsp1_valid,
  output logic [SHARE_W-1:0]  rsp0_c,
  output logic [SHARE_W-1:0]  rsp1_c,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  logic        rr_q;  // 1: req1 wins the next contested cycle
  pipe_stage_t pipe_q [GADGET_LAT];
  logic [CNT_W-1:0] cnt_q;

  logic arb_en_c;
  logic gnt0_c;
  logic gnt1_c;
  logic gnt_any_c;
  logic busy_c;

  // Grants depend only on valids, priority and blocking conditions, never on operand data.
  always_comb begin
    arb_en_c  = !rst && !seed_valid;
    gnt0_c    = arb_en_c && req0_valid && (!req1_valid || !rr_q);
    gnt1_c    = arb_en_c && req1_valid && (!req0_valid ||  rr_q);
    gnt_any_c = gnt0_c || gnt1_c;
  end

  assign req0_ready = gnt0_c;
  assign req1_ready = gnt1_c;

  // Operand shares go to the gadget only in the grant cycle; zero otherwise.
  always_comb begin
    g_a = '0;
    g_b = '0;
    if (gnt0_c) begin
      g_a = req0_a;
      g_b = req0_b;
    end else if (gnt1_c) begin
      g_a = req1_a;
      g_b = req1_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= 1'b0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < GADGET_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      if (gnt_any_c) begin
        rr_q  <= gnt0_c;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      pipe_q[0].valid <= gnt_any_c;
      pipe_q[0].tag   <= gnt1_c ? REQ1 : REQ0;
      for (int unsigned i = 1; i < GADGET_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int unsigned i = 0; i < GADGET_LAT; i++) begin
      busy_c = busy_c | pipe_q[i].valid;
    end
  end

  assign busy       = busy_c;
  assign op_count   = cnt_q;
  assign rsp0_valid = pipe_q[GADGET_LAT-1].valid && (pipe_q[GADGET_LAT-1].tag == REQ0);
  assign rsp1_valid = pipe_q[GADGET_LAT-1].valid && (pipe_q[GADGET_LAT-1].tag == REQ1);
  assign rsp0_c     = g_c;
  assign rsp1_c     = g_c;

  comar_lfsr6 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (seed_valid),
    .seed (seed),
    .rnd  (g_r)
  );

endmodule

// File: tb/tb_comar_nor_sched.sv
// Self-checking bench for comar_nor_sched with a behavioural model and a 2-cycle gadget model.
module tb_comar_nor_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_valid;
  logic [30:0] seed;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic [1:0]  g_a, g_b, g_c;
  logic [5:0]  g_r;
  logic        rsp0_valid, rsp1_valid;
  logic [1:0]  rsp0_c, rsp1_c;
  logic        busy;
  logic [15:0] op_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  comar_nor_sched dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed       (seed),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .g_a        (g_a),
    .g_b        (g_b),
    .g_r        (g_r),
    .g_c        (g_c),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp0_c     (rsp0_c),
    .rsp1_c     (rsp1_c),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Gadget stand-in: result shares are {r ^ nor, r} two cycles after the operands.
  logic [1:0] ga1, gb1, ga2, gb2;
  logic [5:0] gr1, gr2;
  always @(posedge clk) begin
    ga1 <= g_a; gb1 <= g_b; gr1 <= g_r;
    ga2 <= ga1; gb2 <= gb1; gr2 <= gr1;
  end
  assign g_c = {gr2[0] ^ ~((ga2[0] ^ ga2[1]) | (gb2[0] ^ gb2[1])), gr2[0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned cyc;
    bit          id;
    bit          nv;
  } op_t;

  op_t         q[$];
  int unsigned cyc = 0;
  bit [30:0]   m_lfsr;
  bit          m_last;
  bit [15:0]   m_cnt;
  int unsigned m_grants;
  bit          check_en = 1'b0;

  function automatic bit [30:0] adv6(input bit [30:0] s);
    bit [30:0] r;
    r = s;
    for (int k = 0; k < 6; k++)
      r = 31'((r << 1) | 31'(((r >> 30) ^ (r >> 27)) & 31'h1));
    return r;
  endfunction

  function automatic bit [1:0] exp_gnt();
    bit w0, w1;
    w0 = !rst && !seed_valid && req0_valid && (!req1_valid || m_last);
    w1 = !rst && !seed_valid && req1_valid && (!req0_valid || !m_last);
    return {w1, w0};
  endfunction

  function automatic bit unmasked_nor(input logic [1:0] a, input logic [1:0] b);
    return !((a[0] ^ a[1]) | (b[0] ^ b[1]));
  endfunction

  always @(posedge clk) begin
    bit [1:0] g;
    op_t o;
    g = exp_gnt();
    if (rst) begin
      q.delete();
      m_lfsr   = 31'h1;
      m_last   = 1'b1;
      m_cnt    = '0;
      m_grants = 0;
    end else begin
      while (q.size() > 0 && q[0].cyc + 2 <= cyc) void'(q.pop_front());
      if (g != 2'b00) begin
        o.cyc = cyc;
        o.id  = g[1];
        o.nv  = g[1] ? unmasked_nor(req1_a, req1_b) : unmasked_nor(req0_a, req0_b);
        q.push_back(o);
        m_last = g[1];
        m_cnt  = m_cnt + 16'd1;
        m_grants++;
      end
      if (seed_valid) m_lfsr = (seed == 31'h0) ? 31'h1 : seed;
      else            m_lfsr = adv6(m_lfsr);
    end
    cyc++;
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      bit [1:0] g;
      bit [1:0] ea, eb;
      bit e0, e1, env;
      g  = exp_gnt();
      ea = g[0] ? req0_a : (g[1] ? req1_a : 2'b00);
      eb = g[0] ? req0_b : (g[1] ? req1_b : 2'b00);
      e0 = 1'b0; e1 = 1'b0; env = 1'b0;
      if (q.size() > 0 && q[0].cyc + 2 == cyc) begin
        e0  = !q[0].id;
        e1  =  q[0].id;
        env =  q[0].nv;
      end
      chk("req0_ready", 32'(req0_ready), 32'(g[0]));
      chk("req1_ready", 32'(req1_ready), 32'(g[1]));
      chk("g_a", 32'(g_a), 32'(ea));
      chk("g_b", 32'(g_b), 32'(eb));
      chk("rsp0_valid", 32'(rsp0_valid), 32'(e0));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(e1));
      if (e0) chk("rsp0_value", 32'(rsp0_c[0] ^ rsp0_c[1]), 32'(env));
      if (e1) chk("rsp1_value", 32'(rsp1_c[0] ^ rsp1_c[1]), 32'(env));
      chk("rsp0_c", 32'(rsp0_c), 32'(g_c));
      chk("rsp1_c", 32'(rsp1_c), 32'(g_c));
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("g_r", 32'(g_r), 32'(m_lfsr[5:0]));
      chk("op_count", 32'(op_count), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    seed_valid = 1'b0; seed = '0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int changes;
    logic [5:0] prev_r;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    check_en = 1'b1;

    // Reset state.
    #1;
    chk("rst_g_r", 32'(g_r), 32'h01);
    chk("rst_op_count", 32'(op_count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single operation from req0: a=1, b=0 -> NOR 0 in cycle 2.
    req0_valid = 1'b1; req0_a = 2'b01; req0_b = 2'b00;
    #1;
    chk("c0_ready0", 32'(req0_ready), 32'h1);
    chk("c0_g_a", 32'(g_a), 32'h1);
    tick();
    idle();
    #1;
    chk("c1_g_r", 32'(g_r), 32'h00);
    chk("c1_busy", 32'(busy), 32'h1);
    tick();
    #1;
    chk("c2_rsp0_valid", 32'(rsp0_valid), 32'h1);
    chk("c2_rsp0_value", 32'(rsp0_c[0] ^ rsp0_c[1]), 32'h0);
    chk("c2_rsp1_valid", 32'(rsp1_valid), 32'h0);
    tick();

    // Both requesters continuously for 6 cycles: strict alternation.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req0_valid = (i < 6); req0_a = 2'b11; req0_b = 2'b10;
      req1_valid = (i < 6); req1_a = 2'b00; req1_b = 2'b00;
      #1;
      if (i < 6) begin
        chk("alt_ready0", 32'(req0_ready), 32'(i % 2 == 0));
        chk("alt_ready1", 32'(req1_ready), 32'(i % 2 == 1));
      end
      if (i >= 2) begin
        chk("alt_rsp0", 32'(rsp0_valid), 32'(i % 2 == 0));
        chk("alt_rsp1", 32'(rsp1_valid), 32'(i % 2 == 1));
      end
      tick();
    end
    idle();
    #1;
    chk("alt_op_count", 32'(op_count), 32'h6);

    // Seed loads: zero falls back to 1; readys blocked in the load cycle.
    seed_valid = 1'b1; seed = 31'h0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("seed_ready0", 32'(req0_ready), 32'h0);
    chk("seed_ready1", 32'(req1_ready), 32'h0);
    tick();
    idle();
    #1;
    chk("seed0_g_r", 32'(g_r), 32'h01);
    seed_valid = 1'b1; seed = 31'h4000_0000;
    tick();
    idle();
    #1;
    chk("seedhi_g_r", 32'(g_r), 32'h00);
    tick();
    #1;
    chk("seedhi_adv_g_r", 32'(g_r), 32'h20);

    // Reset one cycle after acceptance discards the operation.
    do_reset();
    req0_valid = 1'b1; req0_a = 2'b10; req0_b = 2'b01;
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("rstmid_ready0", 32'(req0_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_c2_rsp0", 32'(rsp0_valid), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    tick();
    #1;
    chk("rstmid_c3_rsp0", 32'(rsp0_valid), 32'h0);

    // Random traffic with occasional reseeding.
    do_reset();
    changes = 0;
    prev_r  = g_r;
    for (int i = 0; i < 1000; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 2'($urandom); req0_b = 2'($urandom);
      req1_a = 2'($urandom); req1_b = 2'($urandom);
      seed_valid = ($urandom_range(0, 19) == 0);
      seed = ($urandom_range(0, 1) == 0) ? 31'h0 : 31'($urandom);
      tick();
      if (g_r != prev_r) changes++;
      prev_r = g_r;
    end
    idle();
    #1;
    chk("rand_g_r_moving", 32'(changes > 800), 32'h1);
    chk("rand_op_count", 32'(op_count), 32'(16'(m_grants)));

    // Counter wrap after 65536 grants.
    do_reset();
    req0_valid = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    idle();
    #1;
    chk("wrap_pre", 32'(op_count), 32'hFFFF);
    req1_valid = 1'b1;
    tick();
    idle();
    #1;
    chk("wrap_post", 32'(op_count), 32'h0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
